// File: rtl/accel_rr_scheduler.sv
// Round-robin front end that lets NUM_REQ requesters share one start/finish accelerator,
// returning the captured return value, run latency and a watchdog abort flag to the winner.
module accel_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          result,
  output logic [CNT_W-1:0]           run_cycles,
  output logic                       timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       accel_start,
  input  logic                       accel_finish,
  input  logic [DATA_W-1:0]          accel_return_val
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0]   TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, EXE, DONE} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [ID_W-1:0]   pick_id;
  logic [ID_W:0]     scan_idx;

  // Saturating increment; also the run length reported when the run ends this cycle.
  assign cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    pick_id  = rr_ptr_reg;
    scan_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(i);
      if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      end
      if (req[scan_idx[ID_W-1:0]]) begin
        pick_id = scan_idx[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rr_ptr_reg  <= '0;
      grant_id    <= '0;
      ack         <= '0;
      result      <= '0;
      run_cycles  <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      accel_start <= 1'b0;
    end else begin
      accel_start <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_id    <= pick_id;
            accel_start <= 1'b1;
            busy        <= 1'b1;
            state_reg   <= START;
          end
        end
        START: begin
          cnt_reg   <= '0;
          state_reg <= EXE;
        end
        EXE: begin
          cnt_reg <= cnt_next;
          if (accel_finish) begin
            result     <= accel_return_val;
            run_cycles <= cnt_next;
            ack        <= ONE_HOT0 << grant_id;
            state_reg  <= DONE;
          end else if (TIMEOUT != 0 && cnt_next == TIMEOUT_C) begin
            // Watchdog abort: the pulse on timeout_err lines up with ack in DONE.
            result      <= '0;
            run_cycles  <= TIMEOUT_C;
            timeout_err <= 1'b1;
            ack         <= ONE_HOT0 << grant_id;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          rr_ptr_reg <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
          busy       <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_rr_scheduler.sv
// Bench for accel_rr_scheduler: directed scenarios with literal expectations, then random
// traffic checked every cycle against a run-timeline model of the scheduler.
module tb_accel_rr_scheduler;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int CW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  ack;
  logic [DW-1:0] result;
  logic [CW-1:0] run_cycles;
  logic          timeout_err;
  logic [1:0]    grant_id;
  logic          busy;
  logic          accel_start;
  logic          accel_finish = 1'b0;
  logic [DW-1:0] accel_return_val = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  accel_rr_scheduler #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ack(ack), .result(result),
    .run_cycles(run_cycles), .timeout_err(timeout_err), .grant_id(grant_id), .busy(busy),
    .accel_start(accel_start), .accel_finish(accel_finish), .accel_return_val(accel_return_val)
  );

  // Model: a run granted at edge S with accelerator latency L ends after min(L,TMO) EXE edges,
  // so ack follows edge S+1+min(L,TMO) and the scheduler is idle again after the next edge.
  int            e = 0;
  bit            run_active = 0;
  int            m_g = 0, m_start = 0, m_lat = 0, m_leff = 0, m_rr = 0;
  logic [DW-1:0] m_val = '0;
  int            next_lat = 1;
  logic [DW-1:0] next_val = '0;
  bit            check_en = 0;
  bit            spurious_en = 0;

  logic [N-1:0]  exp_ack = '0;
  logic [DW-1:0] exp_result = '0;
  logic [CW-1:0] exp_rc = '0;
  logic          exp_to = 1'b0;
  logic [1:0]    exp_gid = '0;
  logic          exp_busy = 1'b0;
  logic          exp_start = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic int pick(logic [N-1:0] r, int rr);
    for (int k = 0; k < N; k++) begin
      if (r[(rr + k) % N]) return (rr + k) % N;
    end
    return 0;
  endfunction

  function automatic int rand_lat();
    case ($urandom_range(9))
      0: return 16;
      1: return 15;
      2: return 17;
      3: return 1000;
      4: return 1;
      default: return int'($urandom_range(2, 12));
    endcase
  endfunction

  task automatic model_reset();
    run_active = 0;
    m_rr       = 0;
    exp_ack    = '0;
    exp_result = '0;
    exp_rc     = '0;
    exp_to     = 1'b0;
    exp_gid    = '0;
    exp_busy   = 1'b0;
    exp_start  = 1'b0;
  endtask

  task automatic model_step();
    e++;
    if (!reset_n) begin
      model_reset();
      return;
    end
    exp_start = 1'b0;
    exp_ack   = '0;
    exp_to    = 1'b0;
    if (run_active) begin
      if (e == m_start + 1 + m_leff) begin
        exp_ack    = N'(1) << m_g;
        exp_to     = (m_lat > TMO);
        exp_result = exp_to ? '0 : m_val;
        exp_rc     = CW'(m_leff);
      end
      if (e == m_start + 2 + m_leff) begin
        m_rr       = (m_g + 1) % N;
        run_active = 0;
        exp_busy   = 1'b0;
      end
    end else if (req != '0) begin
      m_g        = pick(req, m_rr);
      m_start    = e;
      m_lat      = next_lat;
      m_val      = next_val;
      m_leff     = (m_lat < TMO) ? m_lat : TMO;
      run_active = 1;
      exp_gid    = 2'(m_g);
      exp_start  = 1'b1;
      exp_busy   = 1'b1;
    end
  endtask

  // One clock: advance the model on the edge, then drive the accelerator for the next edge.
  task automatic tick();
    bit sched;
    bit in_exe;
    @(posedge clk);
    model_step();
    #1;
    sched  = reset_n && run_active && (m_lat <= TMO) && (e + 1 == m_start + 1 + m_lat);
    in_exe = run_active && (e + 1 >= m_start + 2) && (e + 1 <= m_start + 1 + m_leff);
    accel_finish     = sched;
    accel_return_val = sched ? m_val : DW'($urandom);
    if (!sched && !in_exe && spurious_en && reset_n && $urandom_range(7) == 0) begin
      accel_finish = 1'b1;
    end
  endtask

  task automatic run_until_ack(output int gid, output logic [DW-1:0] res, output int rc,
                               output bit to, output int starts, output int lat);
    int t_start;
    bit seen;
    starts = 0; t_start = 0; seen = 0; gid = -1; res = '0; rc = -1; to = 0; lat = -1;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (accel_start === 1'b1) begin
        starts++;
        t_start = i;
      end
      if (ack !== '0) begin
        seen = 1;
        gid  = int'(grant_id);
        res  = result;
        rc   = int'(run_cycles);
        to   = timeout_err;
        lat  = i - t_start;
        req  = req & ~ack;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_until_ack: no ack within 200 cycles (t=%0t)", $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("ack", 64'(ack), 64'(exp_ack));
      chk("result", 64'(result), 64'(exp_result));
      chk("run_cycles", 64'(run_cycles), 64'(exp_rc));
      chk("timeout_err", 64'(timeout_err), 64'(exp_to));
      chk("grant_id", 64'(grant_id), 64'(exp_gid));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("accel_start", 64'(accel_start), 64'(exp_start));
      if (exp_ack != '0) begin
        $display("[TB] t=%0t ack=%b gid=%0d result=0x%0h cycles=%0d timeout=%0b",
                 $time, ack, grant_id, result, run_cycles, timeout_err);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int gid, rc, starts, lat;
    bit to;
    logic [DW-1:0] res;
    logic [N-1:0] r;

    #1;
    reset_n = 1'b0;
    model_reset();
    check_en = 1;
    repeat (3) tick();
    chk("reset_ack", 64'(ack), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_result", 64'(result), 64'(0));
    reset_n = 1'b1;
    tick();

    // Round-robin from reset with all four requesting.
    req = 4'b1111;
    next_lat = 3;
    for (int k = 0; k < 4; k++) begin
      next_val = 32'h100 + k;
      run_until_ack(gid, res, rc, to, starts, lat);
      chk("rr_order", 64'(gid), 64'(k));
      chk("rr_starts", 64'(starts), 64'(1));
      chk("rr_cycles", 64'(rc), 64'(3));
      chk("rr_result", 64'(res), 64'(32'h100 + k));
    end

    // Pointer wraps from 3 back to 0.
    req = 4'b1001;
    next_val = 32'h55;
    run_until_ack(gid, res, rc, to, starts, lat);
    chk("wrap_first", 64'(gid), 64'(0));
    run_until_ack(gid, res, rc, to, starts, lat);
    chk("wrap_second", 64'(gid), 64'(3));

    // Single run, finish 5 cycles after start.
    req = 4'b0100;
    next_lat = 5;
    next_val = 32'h0000002A;
    run_until_ack(gid, res, rc, to, starts, lat);
    chk("single_gid", 64'(gid), 64'(2));
    chk("single_result", 64'(res), 64'h2A);
    chk("single_cycles", 64'(rc), 64'(5));
    chk("single_timeout", 64'(to), 64'(0));
    chk("single_starts", 64'(starts), 64'(1));
    chk("single_latency", 64'(lat), 64'(6));

    // Watchdog abort.
    req = 4'b0010;
    next_lat = 1000;
    next_val = 32'hFFFF0000;
    run_until_ack(gid, res, rc, to, starts, lat);
    chk("wd_gid", 64'(gid), 64'(1));
    chk("wd_timeout", 64'(to), 64'(1));
    chk("wd_result", 64'(res), 64'(0));
    chk("wd_cycles", 64'(rc), 64'(16));
    chk("wd_latency", 64'(lat), 64'(17));
    tick();
    chk("wd_idle", 64'(busy), 64'(0));

    // Finish on the same cycle the watchdog expires.
    req = 4'b1000;
    next_lat = 16;
    next_val = 32'hDEADBEEF;
    run_until_ack(gid, res, rc, to, starts, lat);
    chk("coinc_gid", 64'(gid), 64'(3));
    chk("coinc_timeout", 64'(to), 64'(0));
    chk("coinc_result", 64'(res), 64'hDEADBEEF);
    chk("coinc_cycles", 64'(rc), 64'(16));

    req = 4'b0100;
    next_lat = 2;
    next_val = 32'h7;
    run_until_ack(gid, res, rc, to, starts, lat);
    chk("pre_rst_gid", 64'(gid), 64'(2));

    // Reset in the middle of EXE; rr pointer was 3 and must come back as 0.
    req = 4'b0001;
    next_lat = 1000;
    repeat (6) tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_ack", 64'(ack), 64'(0));
    chk("arst_result", 64'(result), 64'(0));
    chk("arst_cycles", 64'(run_cycles), 64'(0));
    chk("arst_timeout", 64'(timeout_err), 64'(0));
    chk("arst_gid", 64'(grant_id), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_start", 64'(accel_start), 64'(0));
    repeat (2) tick();
    req = 4'b1010;
    reset_n = 1'b1;
    next_lat = 4;
    next_val = 32'h1234;
    run_until_ack(gid, res, rc, to, starts, lat);
    chk("post_rst_gid", 64'(gid), 64'(1));
    chk("post_rst_result", 64'(res), 64'h1234);
    chk("post_rst_cycles", 64'(rc), 64'(4));
    chk("post_rst_timeout", 64'(to), 64'(0));

    // Random traffic with spurious finish pulses outside EXE.
    req = '0;
    spurious_en = 1;
    next_lat = rand_lat();
    next_val = $urandom;
    repeat (3000) begin
      tick();
      if (exp_start) begin
        next_lat = rand_lat();
        next_val = $urandom;
      end
      r = req & ~exp_ack;
      if (run_active && $urandom_range(15) == 0) r[m_g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!r[i] && !exp_ack[i] && $urandom_range(3) == 0) r[i] = 1'b1;
      end
      req = r;
    end
    req = '0;
    repeat (60) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
